// File: rtl/nn_config_loader.sv
// nn_config_loader: turns a 32-bit valid/ready host word stream into the shared
// neuron configuration bus (layer/neuron select plus weight and bias strobes).
// Optional feature macro: CFG_CHECKSUM_EN. When it is defined, each weight block
// is followed by an XOR checksum word, which is verified before the next header.
module nn_config_loader #(
    parameter int maxCount = 784
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        weightValid,
    output logic [31:0] weightValue,
    output logic        biasValid,
    output logic [31:0] biasValue,
    output logic [31:0] config_layer_num,
    output logic [31:0] config_neuron_num,
    output logic        done,
    output logic        error,
    output logic [15:0] blockCount
);

`ifdef CFG_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_HDR, ST_WGT, ST_BIAS, ST_CHK, ST_DONE, ST_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_HDR, ST_WGT, ST_BIAS, ST_DONE, ST_ERR
    } state_t;
`endif

    localparam logic [11:0] MAX_COUNT = 12'(maxCount);

    // Header type codes
    localparam logic [1:0] TYPE_WEIGHT = 2'b00;
    localparam logic [1:0] TYPE_BIAS   = 2'b01;
    localparam logic [1:0] TYPE_END    = 2'b11;

    state_t      state_reg;
    logic [11:0] remaining_reg;
`ifdef CFG_CHECKSUM_EN
    logic [31:0] csum_reg;
`endif

    logic        xfer;
    logic [1:0]  hdr_type;
    logic [5:0]  hdr_layer;
    logic [11:0] hdr_neuron;
    logic [11:0] hdr_count;

    assign xfer       = s_valid & s_ready;
    assign hdr_type   = s_data[31:30];
    assign hdr_layer  = s_data[29:24];
    assign hdr_neuron = s_data[23:12];
    assign hdr_count  = s_data[11:0];

    // Single FSM: decodes headers, forwards data words as one-cycle strobes,
    // and drives every output from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_HDR;
            remaining_reg     <= '0;
`ifdef CFG_CHECKSUM_EN
            csum_reg          <= '0;
`endif
            s_ready           <= 1'b0;
            weightValid       <= 1'b0;
            weightValue       <= '0;
            biasValid         <= 1'b0;
            biasValue         <= '0;
            config_layer_num  <= 32'hFFFF_FFFF;
            config_neuron_num <= 32'hFFFF_FFFF;
            done              <= 1'b0;
            error             <= 1'b0;
            blockCount        <= '0;
        end else begin
            // Strobes last one cycle; ready stays high unless a terminal state is entered.
            weightValid <= 1'b0;
            biasValid   <= 1'b0;
            s_ready     <= 1'b1;

            case (state_reg)
                ST_HDR: begin
                    if (xfer) begin
                        case (hdr_type)
                            TYPE_WEIGHT: begin
                                if (hdr_count == 12'd0 || hdr_count > MAX_COUNT) begin
                                    state_reg <= ST_ERR;
                                    error     <= 1'b1;
                                    s_ready   <= 1'b0;
                                end else begin
                                    config_layer_num  <= {26'd0, hdr_layer};
                                    config_neuron_num <= {20'd0, hdr_neuron};
                                    remaining_reg     <= hdr_count;
`ifdef CFG_CHECKSUM_EN
                                    csum_reg          <= '0;
`endif
                                    state_reg         <= ST_WGT;
                                end
                            end
                            TYPE_BIAS: begin
                                // Count field is meaningless for a bias block.
                                config_layer_num  <= {26'd0, hdr_layer};
                                config_neuron_num <= {20'd0, hdr_neuron};
`ifdef CFG_CHECKSUM_EN
                                csum_reg          <= '0;
`endif
                                state_reg         <= ST_BIAS;
                            end
                            TYPE_END: begin
                                state_reg <= ST_DONE;
                                done      <= 1'b1;
                                s_ready   <= 1'b0;
                            end
                            default: begin
                                state_reg <= ST_ERR;
                                error     <= 1'b1;
                                s_ready   <= 1'b0;
                            end
                        endcase
                    end
                end

                ST_WGT: begin
                    if (xfer) begin
                        weightValid   <= 1'b1;
                        weightValue   <= s_data;
                        remaining_reg <= remaining_reg - 12'd1;
`ifdef CFG_CHECKSUM_EN
                        csum_reg      <= csum_reg ^ s_data;
                        if (remaining_reg == 12'd1) begin
                            state_reg <= ST_CHK;
                        end
`else
                        if (remaining_reg == 12'd1) begin
                            state_reg  <= ST_HDR;
                            blockCount <= blockCount + 16'd1;
                        end
`endif
                    end
                end

                ST_BIAS: begin
                    if (xfer) begin
                        biasValid  <= 1'b1;
                        biasValue  <= s_data;
                        blockCount <= blockCount + 16'd1;
                        state_reg  <= ST_HDR;
                    end
                end

`ifdef CFG_CHECKSUM_EN
                ST_CHK: begin
                    // Checksum word is consumed silently; a mismatch poisons the stream.
                    if (xfer) begin
                        if (s_data == csum_reg) begin
                            blockCount <= blockCount + 16'd1;
                            state_reg  <= ST_HDR;
                        end else begin
                            state_reg <= ST_ERR;
                            error     <= 1'b1;
                            s_ready   <= 1'b0;
                        end
                    end
                end
`endif

                ST_DONE: s_ready <= 1'b0;
                ST_ERR:  s_ready <= 1'b0;
                default: begin
                    state_reg <= ST_ERR;
                    error     <= 1'b1;
                    s_ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_config_loader.sv
// Testbench for nn_config_loader: scoreboard of expected strobes, popped by a
// monitor on every strobe cycle, plus per-scenario inline status checks.
module tb_nn_config_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        weightValid;
    logic [31:0] weightValue;
    logic        biasValid;
    logic [31:0] biasValue;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic        done;
    logic        error;
    logic [15:0] blockCount;

    always #5 clk = ~clk;

    nn_config_loader dut (
        .clk               (clk),
        .rst               (rst),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .weightValid       (weightValid),
        .weightValue       (weightValue),
        .biasValid         (biasValid),
        .biasValue         (biasValue),
        .config_layer_num  (config_layer_num),
        .config_neuron_num (config_neuron_num),
        .done              (done),
        .error             (error),
        .blockCount        (blockCount)
    );

    typedef struct {
        bit          is_bias;
        logic [31:0] value;
        logic [31:0] layer;
        logic [31:0] neuron;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   strobe_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expected entry, including its cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (weightValid === 1'b1 || biasValid === 1'b1) begin
            strobe_count++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL strobe_unexpected: got w=%b b=%b wval=%h bval=%h at cyc %0d, required no strobe",
                         weightValid, biasValid, weightValue, biasValue, cyc);
            end else begin
                e = sb.pop_front();
                if (weightValid !== !e.is_bias || biasValid !== e.is_bias ||
                    (e.is_bias ? biasValue : weightValue) !== e.value ||
                    config_layer_num !== e.layer || config_neuron_num !== e.neuron ||
                    cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL strobe: got w=%b b=%b val=%h layer=%h neuron=%h cyc=%0d, required bias=%b val=%h layer=%h neuron=%h cyc=%0d",
                             weightValid, biasValid, e.is_bias ? biasValue : weightValue,
                             config_layer_num, config_neuron_num, cyc,
                             e.is_bias, e.value, e.layer, e.neuron, e.cyc);
                end else begin
                    $display("strobe ok: bias=%b val=%h layer=%0d neuron=%0d cyc=%0d",
                             e.is_bias, e.value, e.layer, e.neuron, cyc);
                end
            end
        end
    end

    // Offer one word; when push is set the word is expected back as a strobe next cycle
    task automatic send(input logic [31:0] w, input bit push, input bit is_bias,
                        input logic [31:0] lay, input logic [31:0] neu);
        int n;
        n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        while (s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (s_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: s_ready=%b for word %h, required 1", s_ready, w);
        end else if (push) begin
            sb.push_back('{is_bias, w, lay, neu, cyc + 1});
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_data  = $urandom;
        end
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({s_ready, weightValid, biasValid, done, error} !== 5'b0 ||
            weightValue !== 32'd0 || biasValue !== 32'd0 || blockCount !== 16'd0 ||
            config_layer_num !== 32'hFFFF_FFFF || config_neuron_num !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL reset_values: got rdy=%b wv=%b bv=%b done=%b err=%b wval=%h bval=%h bc=%h layer=%h neuron=%h, required zeros and FFFFFFFF config",
                     s_ready, weightValid, biasValid, done, error, weightValue, biasValue,
                     blockCount, config_layer_num, config_neuron_num);
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got s_ready=%b, required 1", s_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_weight;
        int s0;
        s0 = strobe_count;
        send(32'h0100_3004, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) send(32'(i), 1, 0, 32'd1, 32'd3);
`ifdef CFG_CHECKSUM_EN
        send(32'h0000_0004, 0, 0, 0, 0);
`endif
        idle(2);
        n_cmp++;
        if (strobe_count - s0 != 4 || blockCount !== 16'd1 ||
            config_layer_num !== 32'd1 || config_neuron_num !== 32'd3) begin
            n_err++;
            $display("FAIL weight_block: got strobes=%0d bc=%0d layer=%h neuron=%h, required 4 1 1 3",
                     strobe_count - s0, blockCount, config_layer_num, config_neuron_num);
        end
        $display("test_weight done");
    endtask

    task automatic test_bias;
        int s0;
        s0 = strobe_count;
        send(32'h4100_3000, 0, 0, 0, 0);
        send(32'h0000_FFF0, 1, 1, 32'd1, 32'd3);
        idle(2);
        n_cmp++;
        if (strobe_count - s0 != 1 || blockCount !== 16'd2) begin
            n_err++;
            $display("FAIL bias_block: got strobes=%0d bc=%0d, required 1 2",
                     strobe_count - s0, blockCount);
        end
        $display("test_bias done");
    endtask

    task automatic test_back_to_back;
        int s0;
        s0 = strobe_count;
        send(32'h0200_5002, 0, 0, 0, 0);
        send(32'hAAAA_0001, 1, 0, 32'd2, 32'd5);
        send(32'h5555_0010, 1, 0, 32'd2, 32'd5);
`ifdef CFG_CHECKSUM_EN
        send(32'hAAAA_0001 ^ 32'h5555_0010, 0, 0, 0, 0);
`endif
        send(32'h0300_7001, 0, 0, 0, 0);
        send(32'hDEAD_BEEF, 1, 0, 32'd3, 32'd7);
`ifdef CFG_CHECKSUM_EN
        send(32'hDEAD_BEEF, 0, 0, 0, 0);
`endif
        idle(2);
        n_cmp++;
        if (strobe_count - s0 != 3 || blockCount !== 16'd4 ||
            config_layer_num !== 32'd3 || config_neuron_num !== 32'd7) begin
            n_err++;
            $display("FAIL back_to_back: got strobes=%0d bc=%0d layer=%h neuron=%h, required 3 4 3 7",
                     strobe_count - s0, blockCount, config_layer_num, config_neuron_num);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_max_count;
        int s0;
        logic [31:0] x;
        s0 = strobe_count;
        x  = 32'd0;
        send(32'h0000_1310, 0, 0, 0, 0);
        for (int i = 0; i < 784; i++) begin
            send(32'(i * 3 + 7), 1, 0, 32'd0, 32'd1);
            x = x ^ 32'(i * 3 + 7);
        end
`ifdef CFG_CHECKSUM_EN
        send(x, 0, 0, 0, 0);
`endif
        idle(2);
        n_cmp++;
        if (strobe_count - s0 != 784 || blockCount !== 16'd5 || error !== 1'b0) begin
            n_err++;
            $display("FAIL max_count: got strobes=%0d bc=%0d err=%b, required 784 5 0",
                     strobe_count - s0, blockCount, error);
        end
        $display("test_max_count done (x=%h)", x);
    endtask

    task automatic test_random_valid;
        int s0;
        logic [31:0] x;
        s0 = strobe_count;
        x  = 32'd0;
        send(32'h0500_9004, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            idle($urandom_range(0, 2));
            send(32'h1000_0000 + 32'(i), 1, 0, 32'd5, 32'd9);
            x = x ^ (32'h1000_0000 + 32'(i));
        end
`ifdef CFG_CHECKSUM_EN
        idle($urandom_range(0, 2));
        send(x, 0, 0, 0, 0);
`endif
        idle(2);
        n_cmp++;
        if (strobe_count - s0 != 4 || blockCount !== 16'd6) begin
            n_err++;
            $display("FAIL random_valid: got strobes=%0d bc=%0d, required 4 6",
                     strobe_count - s0, blockCount);
        end
        $display("test_random_valid done (x=%h)", x);
    endtask

    task automatic test_error_hdr(input logic [31:0] h);
        int s0;
        apply_reset;
        s0 = strobe_count;
        send(h, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b1 || s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL error_rise hdr=%h: got err=%b rdy=%b, required 1 0", h, error, s_ready);
        end
        s_valid = 1'b1;
        s_data  = 32'h0100_3004;
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        n_cmp++;
        if (error !== 1'b1 || s_ready !== 1'b0 || done !== 1'b0 || strobe_count != s0 ||
            config_layer_num !== 32'hFFFF_FFFF || config_neuron_num !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL error_sticky hdr=%h: got err=%b rdy=%b done=%b strobes=%0d layer=%h, required 1 0 0 0 FFFFFFFF",
                     h, error, s_ready, done, strobe_count - s0, config_layer_num);
        end
        $display("test_error_hdr %h done", h);
    endtask

`ifdef CFG_CHECKSUM_EN
    task automatic test_bad_checksum;
        apply_reset;
        send(32'h0100_3004, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) send(32'(i), 1, 0, 32'd1, 32'd3);
        send(32'h0000_0005, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b1 || s_ready !== 1'b0 || blockCount !== 16'd0) begin
            n_err++;
            $display("FAIL bad_checksum: got err=%b rdy=%b bc=%0d, required 1 0 0", error, s_ready, blockCount);
        end
        s_valid = 1'b1;
        s_data  = 32'h0200_5002;
        repeat (4) @(negedge clk);
        s_valid = 1'b0;
        n_cmp++;
        if (config_layer_num !== 32'd1 || config_neuron_num !== 32'd3 || error !== 1'b1) begin
            n_err++;
            $display("FAIL bad_checksum_hold: got layer=%h neuron=%h err=%b, required 1 3 1",
                     config_layer_num, config_neuron_num, error);
        end
        $display("test_bad_checksum done");
    endtask
`endif

    task automatic test_reset_mid_block;
        int s0;
        apply_reset;
        s0 = strobe_count;
        send(32'h0100_3004, 0, 0, 0, 0);
        send(32'd1, 1, 0, 32'd1, 32'd3);
        send(32'd2, 1, 0, 32'd1, 32'd3);
        apply_reset;
        send(32'hC000_0000, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || s_ready !== 1'b0 || error !== 1'b0 ||
            config_layer_num !== 32'hFFFF_FFFF || config_neuron_num !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL reset_mid_done: got done=%b rdy=%b err=%b layer=%h neuron=%h, required 1 0 0 FFFFFFFF FFFFFFFF",
                     done, s_ready, error, config_layer_num, config_neuron_num);
        end
        idle(3);
        n_cmp++;
        if (strobe_count - s0 != 2 || blockCount !== 16'd0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_strobes: got strobes=%0d bc=%0d done=%b, required 2 0 1",
                     strobe_count - s0, blockCount, done);
        end
        $display("test_reset_mid_block done");
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'd0;
        test_reset;
        test_weight;
        test_bias;
        test_back_to_back;
        test_max_count;
        test_random_valid;
        test_error_hdr(32'h8000_0000);
        test_error_hdr(32'h0100_3000);
        test_error_hdr(32'h0100_3311);
`ifdef CFG_CHECKSUM_EN
        test_bad_checksum;
`endif
        test_reset_mid_block;
        idle(2);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending strobes, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
